// File: rtl/mips_datapath_pkg.sv
// mips_datapath_pkg
//   Shared definitions for the multicycle MIPS-subset CPU: opcode and funct
//   encodings, the 4-bit control state enum, the ALU operation enum, and
//   helpers for decode and ALU evaluation.
//   No ports (package).
package mips_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_FETCH0 = 4'd1,
    ST_FETCH1 = 4'd2,
    ST_DECODE = 4'd3,
    ST_EXEC_R = 4'd4,
    ST_EXEC_I = 4'd5,
    ST_MEMADR = 4'd6,
    ST_MEMRD  = 4'd7,
    ST_MEMWR  = 4'd8,
    ST_WBMEM  = 4'd9,
    ST_BRANCH = 4'd10,
    ST_JUMP   = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI
  } alu_op_e;

  // Anything not recognised here falls back to FETCH0, which is how
  // unknown encodings end up behaving as NOPs.
  function automatic state_e decodeNext(input logic [5:0] op, input logic [5:0] funct);
    state_e nxt;
    nxt = ST_FETCH0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: nxt = ST_EXEC_R;
          default: nxt = ST_FETCH0;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: nxt = ST_EXEC_I;
      OP_LW, OP_LB, OP_SW, OP_SB:        nxt = ST_MEMADR;
      OP_BEQ, OP_BNE:                    nxt = ST_BRANCH;
      OP_J:                              nxt = ST_JUMP;
      default:                           nxt = ST_FETCH0;
    endcase
    return nxt;
  endfunction

  function automatic alu_op_e functToAlu(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FN_SUBU: op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SLL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // SLL shifts the second operand (rt); LUI places b[15:0] in the top half.
  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: r = b << sh;
      ALU_LUI: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_datapath_ram.sv
// mips_ram
//   Byte-wide RAM with a MOV/MOC handshake. Words are big-endian: the lowest
//   address of a word holds bits 31:24. Word accesses ignore Addr[1:0].
//   Ports: Clk, Clear (async active-low, clears handshake only, not Mem),
//          MOV (request), Write (1=store), Byte (1=byte access), Addr (byte
//          address), DataIn (store data), DataOut (read data, byte zero-
//          extended), MOC (access complete).
module mips_ram #(
  parameter int MEM_BYTES = 256,
  parameter int MEM_LAT   = 1,
  localparam int AW       = $clog2(MEM_BYTES)
) (
  input  logic          Clk,
  input  logic          Clear,
  input  logic          MOV,
  input  logic          Write,
  input  logic          Byte,
  input  logic [AW-1:0] Addr,
  input  logic [31:0]   DataIn,
  output logic [31:0]   DataOut,
  output logic          MOC
);

  logic [7:0]    Mem [0:MEM_BYTES-1];
  logic [7:0]    cnt_q;
  logic          lastCycle;
  logic          commit;
  logic [AW-1:0] a0, a1, a2, a3;

  assign a0 = {Addr[AW-1:2], 2'd0};
  assign a1 = {Addr[AW-1:2], 2'd1};
  assign a2 = {Addr[AW-1:2], 2'd2};
  assign a3 = {Addr[AW-1:2], 2'd3};

  assign lastCycle = (cnt_q == 8'(MEM_LAT - 1));
  // A store lands on the same edge that raises MOC, exactly once per request.
  // An async clear drops MOV (driven from a cleared register), so an aborted
  // access never reaches this edge.
  assign commit = MOV && !MOC && lastCycle && Write;

  assign DataOut = Byte ? {24'd0, Mem[Addr]} : {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};

  // Handshake timer: counts MEM_LAT cycles of MOV, then holds MOC until MOV drops.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      MOC   <= 1'b0;
      cnt_q <= 8'd0;
    end else if (!MOV) begin
      MOC   <= 1'b0;
      cnt_q <= 8'd0;
    end else if (!MOC) begin
      if (lastCycle) MOC <= 1'b1;
      else           cnt_q <= cnt_q + 8'd1;
    end
  end

  // Storage has no reset so preloaded contents survive a processor reset.
  always_ff @(posedge Clk) begin
    if (commit) begin
      if (Byte) begin
        Mem[Addr] <= DataIn[7:0];
      end else begin
        Mem[a0] <= DataIn[31:24];
        Mem[a1] <= DataIn[23:16];
        Mem[a2] <= DataIn[15:8];
        Mem[a3] <= DataIn[7:0];
      end
    end
  end

endmodule

// File: rtl/mips_datapath_reg.sv
// mips_reg32
//   32-bit register with asynchronous active-low clear to a configurable
//   value and a load enable. Used for MAR, PC, nPC and IR.
//   Ports: Clk (clock), Clear (async active-low), En (load), D (next), Q (value).
module mips_reg32 #(
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        Clk,
  input  logic        Clear,
  input  logic        En,
  input  logic [31:0] D,
  output logic [31:0] Q
);

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear)  Q <= RESET_VAL;
    else if (En) Q <= D;
  end

endmodule

// File: rtl/mips_datapath.sv
// mips_datapath
//   Multicycle MIPS-subset processor: control FSM, 32x32 register file, ALU
//   and RAM with MOV/MOC handshake. PC/nPC pair gives one branch delay slot.
//   Ports: Clk (clock, posedge), Clear (async active-low reset).
module mips_datapath
  import mips_datapath_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int MEM_LAT   = 1
) (
  input logic Clk,
  input logic Clear
);

  localparam int AW = $clog2(MEM_BYTES);

  state_e      st, st_d;
  logic [31:0] rg [0:31];
  logic [31:0] a_q, a_d, b_q, b_d, mdr_q, mdr_d;
  logic        mov_q, mov_d, wr_q, wr_d, byte_q, byte_d;
  logic        pcEn, npcEn, marEn, irEn;
  logic [31:0] pcD, npcD, marD, irD;
  logic [31:0] pc_q, npc_q, mar_q, ir_q;
  logic [31:0] ramData;
  logic        moc;
  logic        rfWe;
  logic [4:0]  rfWa;
  logic [31:0] rfWd;
  logic        unusedMarBits;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sextImm, zextImm;

  assign op      = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign shamt   = ir_q[10:6];
  assign funct   = ir_q[5:0];
  assign sextImm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zextImm = {16'h0000, ir_q[15:0]};

  // Only the low address bits select a RAM byte; higher MAR bits alias.
  assign unusedMarBits = ^mar_q[31:AW];

  mips_reg32                         MAR (.Clk(Clk), .Clear(Clear), .En(marEn), .D(marD), .Q(mar_q));
  mips_reg32                         PC  (.Clk(Clk), .Clear(Clear), .En(pcEn),  .D(pcD),  .Q(pc_q));
  mips_reg32 #(.RESET_VAL(32'd4))    nPC (.Clk(Clk), .Clear(Clear), .En(npcEn), .D(npcD), .Q(npc_q));
  mips_reg32                         IR  (.Clk(Clk), .Clear(Clear), .En(irEn),  .D(irD),  .Q(ir_q));

  mips_ram #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(MEM_LAT)) RAM (
    .Clk(Clk), .Clear(Clear), .MOV(mov_q), .Write(wr_q), .Byte(byte_q),
    .Addr(mar_q[AW-1:0]), .DataIn(b_q), .DataOut(ramData), .MOC(moc)
  );

  // Control and datapath next-state. MOV is a register set alongside MAR so
  // the RAM never sees a request before its address is valid.
  always_comb begin
    st_d   = st;
    a_d    = a_q;
    b_d    = b_q;
    mdr_d  = mdr_q;
    mov_d  = mov_q;
    wr_d   = wr_q;
    byte_d = byte_q;
    pcEn = 1'b0;  pcD  = 32'd0;
    npcEn = 1'b0; npcD = 32'd0;
    marEn = 1'b0; marD = 32'd0;
    irEn = 1'b0;  irD  = 32'd0;
    rfWe = 1'b0;  rfWa = 5'd0; rfWd = 32'd0;
    case (st)
      ST_RESET: st_d = ST_FETCH0;
      ST_FETCH0: begin
        marEn = 1'b1; marD = pc_q;
        mov_d = 1'b1; wr_d = 1'b0; byte_d = 1'b0;
        st_d  = ST_FETCH1;
      end
      ST_FETCH1: begin
        if (moc) begin
          irEn  = 1'b1; irD  = ramData;
          pcEn  = 1'b1; pcD  = npc_q;
          npcEn = 1'b1; npcD = npc_q + 32'd4;
          mov_d = 1'b0;
          st_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d  = (rs == 5'd0) ? 32'd0 : rg[rs];
        b_d  = (rt == 5'd0) ? 32'd0 : rg[rt];
        st_d = decodeNext(op, funct);
      end
      ST_EXEC_R: begin
        rfWe = 1'b1; rfWa = rd;
        rfWd = alu(functToAlu(funct), a_q, b_q, shamt);
        st_d = ST_FETCH0;
      end
      ST_EXEC_I: begin
        rfWe = 1'b1; rfWa = rt;
        case (op)
          OP_ADDIU: rfWd = alu(ALU_ADD, a_q, sextImm, 5'd0);
          OP_ANDI:  rfWd = alu(ALU_AND, a_q, zextImm, 5'd0);
          OP_ORI:   rfWd = alu(ALU_OR,  a_q, zextImm, 5'd0);
          default:  rfWd = alu(ALU_LUI, a_q, zextImm, 5'd0);
        endcase
        st_d = ST_FETCH0;
      end
      ST_MEMADR: begin
        marEn  = 1'b1; marD = a_q + sextImm;
        mov_d  = 1'b1;
        wr_d   = (op == OP_SW) || (op == OP_SB);
        byte_d = (op == OP_LB) || (op == OP_SB);
        st_d   = wr_d ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        if (moc) begin
          mdr_d = byte_q ? {{24{ramData[7]}}, ramData[7:0]} : ramData;
          mov_d = 1'b0;
          st_d  = ST_WBMEM;
        end
      end
      ST_MEMWR: begin
        if (moc) begin
          mov_d = 1'b0;
          st_d  = ST_FETCH0;
        end
      end
      ST_WBMEM: begin
        rfWe = 1'b1; rfWa = rt; rfWd = mdr_q;
        st_d = ST_FETCH0;
      end
      ST_BRANCH: begin
        // PC already points at the delay slot, so the offset is relative to it.
        if ((op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q)) begin
          npcEn = 1'b1; npcD = pc_q + (sextImm << 2);
        end
        st_d = ST_FETCH0;
      end
      ST_JUMP: begin
        npcEn = 1'b1; npcD = {pc_q[31:28], ir_q[25:0], 2'b00};
        st_d  = ST_FETCH0;
      end
      default: st_d = ST_FETCH0;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      st     <= ST_RESET;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      mdr_q  <= 32'd0;
      mov_q  <= 1'b0;
      wr_q   <= 1'b0;
      byte_q <= 1'b0;
    end else begin
      st     <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mdr_q  <= mdr_d;
      mov_q  <= mov_d;
      wr_q   <= wr_d;
      byte_q <= byte_d;
    end
  end

  // Register 0 is never written, so it stays at its cleared value of zero.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 32; i++) rg[i] <= 32'd0;
    end else if (rfWe && (rfWa != 5'd0)) begin
      rg[rfWa] <= rfWd;
    end
  end

endmodule

// File: tb/tb_mips_datapath.sv
module tb_mips_datapath;

  logic Clk = 1'b0;
  logic Clear = 1'b0;

  always #5 Clk = ~Clk;

  mips_datapath #(.MEM_BYTES(256), .MEM_LAT(1)) dut (.Clk(Clk), .Clear(Clear));

  int vectorCount = 0;
  int missCount = 0;

  logic [7:0]  img  [0:255];
  logic [7:0]  mMem [0:255];
  logic [31:0] mReg [0:31];
  logic [5:0]  rFunct [0:5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00};
  logic [5:0]  iOp    [0:3] = '{6'h09, 6'h0C, 6'h0D, 6'h0F};
  logic [5:0]  memOp  [0:3] = '{6'h23, 6'h20, 6'h2B, 6'h28};

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic putWord(input int addr, input logic [31:0] w);
    img[addr]   = w[31:24];
    img[addr+1] = w[23:16];
    img[addr+2] = w[15:8];
    img[addr+3] = w[7:0];
  endtask

  function automatic logic [31:0] dutWord(input int addr);
    return {dut.RAM.Mem[addr], dut.RAM.Mem[addr+1], dut.RAM.Mem[addr+2], dut.RAM.Mem[addr+3]};
  endfunction

  function automatic logic [31:0] mWord(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {mMem[b], mMem[b+8'd1], mMem[b+8'd2], mMem[b+8'd3]};
  endfunction

  task automatic mWrite(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mReg[r] = v;
  endtask

  // Instruction-level reference: executes from a copy of the image until PC
  // reaches stopPc, with the delay-slot semantics of the PC/nPC pair.
  task automatic modelRun(input logic [31:0] stopPc);
    logic [31:0] pc, npc, ins, a, b, sx, zx, ea;
    logic [7:0]  eb, byteVal;
    logic [4:0]  rt, rd;
    int guard;
    for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
    for (int i = 0; i < 256; i++) mMem[i] = img[i];
    pc = 32'd0; npc = 32'd4; guard = 0;
    while (pc != stopPc && guard < 5000) begin
      ins = mWord(pc);
      pc  = npc;
      npc = npc + 32'd4;
      guard++;
      a  = mReg[ins[25:21]];
      b  = mReg[ins[20:16]];
      rt = ins[20:16];
      rd = ins[15:11];
      sx = {{16{ins[15]}}, ins[15:0]};
      zx = {16'h0000, ins[15:0]};
      ea = a + sx;
      eb = ea[7:0];
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h21: mWrite(rd, a + b);
            6'h23: mWrite(rd, a - b);
            6'h24: mWrite(rd, a & b);
            6'h25: mWrite(rd, a | b);
            6'h2A: mWrite(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h00: mWrite(rd, b << ins[10:6]);
            default: ;
          endcase
        end
        6'h09: mWrite(rt, a + sx);
        6'h0C: mWrite(rt, a & zx);
        6'h0D: mWrite(rt, a | zx);
        6'h0F: mWrite(rt, {ins[15:0], 16'h0000});
        6'h23: mWrite(rt, mWord(ea));
        6'h20: begin
          byteVal = mMem[eb];
          mWrite(rt, {{24{byteVal[7]}}, byteVal});
        end
        6'h2B: begin
          mMem[{eb[7:2], 2'd0}] = b[31:24];
          mMem[{eb[7:2], 2'd1}] = b[23:16];
          mMem[{eb[7:2], 2'd2}] = b[15:8];
          mMem[{eb[7:2], 2'd3}] = b[7:0];
        end
        6'h28: mMem[eb] = b[7:0];
        6'h04: if (a == b) npc = pc + (sx << 2);
        6'h05: if (a != b) npc = pc + (sx << 2);
        6'h02: npc = {pc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] randInstr();
    int kind;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    kind = $urandom_range(0, 14);
    rs   = 5'($urandom_range(0, 7));
    rt   = 5'($urandom_range(0, 7));
    rd   = 5'($urandom_range(0, 7));
    sh   = 5'($urandom_range(0, 31));
    imm  = 16'($urandom);
    if (kind <= 5)       return {6'h00, rs, rt, rd, sh, rFunct[kind]};
    else if (kind <= 9)  return {iOp[kind-6], rs, rt, imm};
    else if (kind <= 13) return {memOp[kind-10], 5'd0, rt, 16'(160 + $urandom_range(0, 95))};
    else                 return {6'h3F, rs, rt, imm};
  endfunction

  task automatic buildRandom();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    for (int k = 0; k < 24; k++) putWord(k * 4, randInstr());
    putWord(96, 32'd0);
    putWord(100, 32'd0);
  endtask

  // Reset the CPU, load the current image into RAM, release reset.
  task automatic applyStimulus();
    Clear = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.RAM.Mem[i] <= img[i];
    @(negedge Clk);
    Clear = 1'b1;
  endtask

  task automatic waitPc(input logic [31:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (dut.PC.Q !== target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checkOutput(tag, dut.PC.Q, target);
  endtask

  task automatic waitState(input logic [3:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (dut.st !== target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    checkOutput(tag, 32'(dut.st), 32'(target));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    putWord(0,  32'h24010005);  // ADDIU $1,$0,5
    putWord(4,  32'h00211021);  // ADDU  $2,$1,$1
    putWord(8,  32'hAC010040);  // SW    $1,64($0)
    putWord(12, 32'h8C030040);  // LW    $3,64($0)
    putWord(16, 32'h800400D0);  // LB    $4,208($0)
    putWord(20, 32'hA00100D9);  // SB    $1,217($0)
    putWord(24, 32'h10000002);  // BEQ   $0,$0,+2
    putWord(28, 32'h24050007);  // delay slot: ADDIU $5,$0,7
    putWord(32, 32'h24060009);  // skipped
    putWord(36, 32'h24070003);  // branch target: ADDIU $7,$0,3
    putWord(40, 32'h14000002);  // BNE $0,$0,+2 (not taken)
    putWord(44, 32'h24080001);  // ADDIU $8,$0,1
    putWord(48, 32'h0800000F);  // J 60
    putWord(52, 32'h240A0004);  // delay slot: ADDIU $10,$0,4
    putWord(56, 32'h240B0006);  // skipped
    putWord(64, 32'hEEEEEEEE);
    img[208] = 8'h80;
    putWord(216, 32'h11223344);

    #1;
    for (int i = 0; i < 256; i++) dut.RAM.Mem[i] <= img[i];
    #6;
    checkOutput("reset st",  32'(dut.st), 32'd0);
    checkOutput("reset PC",  dut.PC.Q,  32'd0);
    checkOutput("reset nPC", dut.nPC.Q, 32'd4);
    checkOutput("reset MAR", dut.MAR.Q, 32'd0);
    checkOutput("reset IR",  dut.IR.Q,  32'd0);
    checkOutput("reset MOC", 32'(dut.RAM.MOC), 32'd0);
    #4;
    Clear = 1'b1;
    @(negedge Clk);
    checkOutput("st after reset", 32'(dut.st), 32'd1);
    @(negedge Clk);
    checkOutput("st fetch1", 32'(dut.st), 32'd2);
    checkOutput("MAR first fetch", dut.MAR.Q, 32'd0);
    waitState(4'd3, 20, "first decode");
    checkOutput("IR first word", dut.IR.Q, 32'h24010005);
    checkOutput("PC after fetch", dut.PC.Q, 32'd4);
    checkOutput("nPC after fetch", dut.nPC.Q, 32'd8);

    waitPc(32'd8, 100, "reach PC 8");
    waitState(4'd1, 20, "ADDU done");
    checkOutput("rg1 ADDIU", dut.rg[1], 32'd5);
    checkOutput("rg2 ADDU",  dut.rg[2], 32'd10);
    checkOutput("PC at 8",   dut.PC.Q,  32'd8);

    waitPc(32'd68, 600, "reach PC 68");
    checkOutput("SW word",        dutWord(64),  32'h00000005);
    checkOutput("rg3 LW",         dut.rg[3],    32'd5);
    checkOutput("rg4 LB sext",    dut.rg[4],    32'hFFFFFF80);
    checkOutput("SB byte only",   dutWord(216), 32'h11053344);
    checkOutput("BEQ delay slot", dut.rg[5],    32'd7);
    checkOutput("BEQ skipped",    dut.rg[6],    32'd0);
    checkOutput("BEQ target",     dut.rg[7],    32'd3);
    checkOutput("BNE fallthru",   dut.rg[8],    32'd1);
    checkOutput("J delay slot",   dut.rg[10],   32'd4);
    checkOutput("J skipped",      dut.rg[11],   32'd0);

    waitState(4'd2, 40, "mid-fetch wait");
    #1;
    Clear = 1'b0;
    #1;
    checkOutput("midreset st",  32'(dut.st), 32'd0);
    checkOutput("midreset PC",  dut.PC.Q,    32'd0);
    checkOutput("midreset nPC", dut.nPC.Q,   32'd4);
    checkOutput("midreset MOC", 32'(dut.RAM.MOC), 32'd0);
    checkOutput("midreset rg1", dut.rg[1],   32'd0);
    checkOutput("midreset Mem0",  dutWord(0),  32'h24010005);
    checkOutput("midreset Mem64", dutWord(64), 32'h00000005);

    for (int it = 0; it < 4; it++) begin
      buildRandom();
      modelRun(32'd104);
      applyStimulus();
      waitPc(32'd104, 2000, $sformatf("rnd%0d finish", it));
      checkOutput($sformatf("rnd%0d rg0", it), dut.rg[0], 32'd0);
      for (int r = 1; r < 8; r++)
        checkOutput($sformatf("rnd%0d rg%0d", it, r), dut.rg[r], mReg[r]);
      for (int a = 160; a < 256; a += 4)
        checkOutput($sformatf("rnd%0d mem%0d", it, a), dutWord(a), mWord(32'(a)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
